// File: rtl/ir_nec_pkg.sv
// rtl/ir_nec_pkg.sv - shared states, default durations and widths for the NEC IR sequencer
package ir_nec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HMARK,
        HSPACE,
        BMARK,
        BSPACE,
        SMARK
    } state_e;

    localparam int HDR_MARK_DEF   = 9000;
    localparam int HDR_SPACE_DEF  = 4500;
    localparam int BIT_MARK_DEF   = 560;
    localparam int ZERO_SPACE_DEF = 560;
    localparam int ONE_SPACE_DEF  = 1690;
    localparam int CNT_W_DEF      = 14;
    localparam int FRAME_BITS     = 32;
    localparam int BIT_IDX_W      = $clog2(FRAME_BITS);

endpackage

// File: rtl/ir_phase_timer.sv
// rtl/ir_phase_timer.sv - tick-driven phase counter that pulses expire on the last tick of a phase
module ir_phase_timer
    import ir_nec_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             in_clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expire must not depend on clear: the owner clears on the expiring cycle.
    assign expire = tick && (cnt_q == (limit - CNT_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ir_nec_sequencer.sv
// rtl/ir_nec_sequencer.sv - sequences one NEC IR frame and drives the carrier enable
module ir_nec_sequencer
    import ir_nec_pkg::*;
#(
    parameter int HDR_MARK   = HDR_MARK_DEF,
    parameter int HDR_SPACE  = HDR_SPACE_DEF,
    parameter int BIT_MARK   = BIT_MARK_DEF,
    parameter int ZERO_SPACE = ZERO_SPACE_DEF,
    parameter int ONE_SPACE  = ONE_SPACE_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic        in_clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        start,
    input  logic [31:0] data,
    output logic        busy,
    output logic        mark,
    output logic        done
);

    state_e               state_q, state_d;
    logic [31:0]          shift_q, shift_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic                 busy_q, busy_d;
    logic                 mark_q, mark_d;
    logic                 done_q, done_d;

    logic                 phase_clear;
    logic                 phase_expire;
    logic [CNT_W-1:0]     phase_limit;

    ir_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .in_clk (in_clk),
        .rst_n  (rst_n),
        .clear  (phase_clear),
        .tick   (tick),
        .limit  (phase_limit),
        .expire (phase_expire)
    );

    always_comb begin
        phase_limit = CNT_W'(BIT_MARK);
        case (state_q)
            HMARK:   phase_limit = CNT_W'(HDR_MARK);
            HSPACE:  phase_limit = CNT_W'(HDR_SPACE);
            BSPACE:  phase_limit = shift_q[0] ? CNT_W'(ONE_SPACE) : CNT_W'(ZERO_SPACE);
            default: phase_limit = CNT_W'(BIT_MARK);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = data;
                    bit_idx_d = '0;
                    state_d   = HMARK;
                end
            end
            HMARK:  if (phase_expire) state_d = HSPACE;
            HSPACE: if (phase_expire) state_d = BMARK;
            BMARK:  if (phase_expire) state_d = BSPACE;
            BSPACE: begin
                if (phase_expire) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    state_d   = (bit_idx_q == BIT_IDX_W'(FRAME_BITS - 1)) ? SMARK : BMARK;
                end
            end
            SMARK: begin
                if (phase_expire) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding the counter clear in IDLE keeps a tick coincident with start uncounted.
    assign phase_clear = (state_q == IDLE) || phase_expire;

    // Outputs are decoded from the next state so they change on the same edge as the state.
    assign busy_d = (state_d != IDLE);
    assign mark_d = (state_d == HMARK) || (state_d == BMARK) || (state_d == SMARK);

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            busy_q    <= 1'b0;
            mark_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            busy_q    <= busy_d;
            mark_q    <= mark_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign mark = mark_q;
    assign done = done_q;

endmodule

// File: tb/tb_ir_nec_sequencer.sv
// tb/tb_ir_nec_sequencer.sv - randomized self-checking bench for ir_nec_sequencer with scaled durations
module tb_ir_nec_sequencer;

    localparam int HM  = 90;
    localparam int HS  = 45;
    localparam int BM  = 6;
    localparam int ZS  = 6;
    localparam int OS  = 17;
    localparam int FRAME_CYC_LIMIT = 6000;

    logic        in_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        tick   = 1'b0;
    logic        start  = 1'b0;
    logic [31:0] data   = '0;
    logic        busy;
    logic        mark;
    logic        done;

    int checks = 0;
    int errors = 0;
    bit tick_en = 1'b0;

    // Monitor state: phase runs of the frame in progress and a snapshot at each done.
    bit cur_lv[$];
    int cur_ln[$];
    bit snap_lv[$];
    int snap_ln[$];
    bit exp_lv[$];
    int exp_ln[$];
    int frame_ticks = 0;
    int snap_ticks  = 0;
    int done_count  = 0;
    bit snap_done_busy = 1'b0;
    bit prev_busy = 1'b0;
    bit prev_mark = 1'b0;

    ir_nec_sequencer #(
        .HDR_MARK   (HM),
        .HDR_SPACE  (HS),
        .BIT_MARK   (BM),
        .ZERO_SPACE (ZS),
        .ONE_SPACE  (OS),
        .CNT_W      (14)
    ) dut (
        .in_clk (in_clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .start  (start),
        .data   (data),
        .busy   (busy),
        .mark   (mark),
        .done   (done)
    );

    always #10 in_clk = ~in_clk;

    initial begin
        forever begin
            @(posedge in_clk);
            #1;
            if (tick) tick = 1'b0;
            else      tick = tick_en && ($urandom_range(0, 2) != 0);
        end
    end

    always @(negedge in_clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
            prev_mark = 1'b0;
        end else begin
            if (busy) begin
                if (!prev_busy) begin
                    cur_lv.delete();
                    cur_ln.delete();
                    frame_ticks = 0;
                end
                if (!prev_busy || mark != prev_mark) begin
                    cur_lv.push_back(mark);
                    cur_ln.push_back(0);
                end
                if (tick) begin
                    cur_ln[cur_ln.size()-1] = cur_ln[cur_ln.size()-1] + 1;
                    frame_ticks++;
                end
            end
            if (done) begin
                snap_lv = cur_lv;
                snap_ln = cur_ln;
                snap_ticks = frame_ticks;
                snap_done_busy = busy;
                done_count++;
            end
            prev_busy = busy;
            prev_mark = mark;
        end
    end

    // Reference frame: header, then a fixed mark and a data-dependent space per bit LSB first, then stop mark.
    function automatic void build_expected(input logic [31:0] d);
        exp_lv.delete();
        exp_ln.delete();
        exp_lv.push_back(1'b1); exp_ln.push_back(HM);
        exp_lv.push_back(1'b0); exp_ln.push_back(HS);
        for (int i = 0; i < 32; i++) begin
            exp_lv.push_back(1'b1); exp_ln.push_back(BM);
            exp_lv.push_back(1'b0); exp_ln.push_back(d[i] ? OS : ZS);
        end
        exp_lv.push_back(1'b1); exp_ln.push_back(BM);
    endfunction

    function automatic int expected_total(input logic [31:0] d);
        int ones = $countones(d);
        return HM + HS + 33 * BM + ones * OS + (32 - ones) * ZS;
    endfunction

    function automatic int run_diffs();
        int n = 0;
        if (snap_ln.size() != exp_ln.size()) return 1000 + snap_ln.size();
        for (int i = 0; i < exp_ln.size(); i++) begin
            if (snap_lv[i] !== exp_lv[i] || snap_ln[i] !== exp_ln[i]) n++;
        end
        return n;
    endfunction

    task automatic pulse_start(input logic [31:0] d);
        @(negedge in_clk); #1;
        data  = d;
        start = 1'b1;
        @(negedge in_clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        int dc;
        @(negedge in_clk); #1;
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (mark !== 1'b0) begin errors++; $display("FAIL reset_mark got %b want 0", mark); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        rst_n = 1'b1;
        tick_en = 1'b1;
        pulse_start($urandom);
        for (int i = 0; i < FRAME_CYC_LIMIT && frame_ticks < 40; i++) begin
            @(negedge in_clk); #1;
        end
        checks += 2;
        if (mark !== 1'b1) begin errors++; $display("FAIL midhdr_mark got %b want 1 (ticks %0d)", mark, frame_ticks); end
        if (busy !== 1'b1) begin errors++; $display("FAIL midhdr_busy got %b want 1", busy); end
        dc = done_count;
        #3 rst_n = 1'b0;
        #1;
        checks += 3;
        if (mark !== 1'b0) begin errors++; $display("FAIL async_rst_mark got %b want 0", mark); end
        if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL async_rst_done got %b want 0", done); end
        repeat (3) @(negedge in_clk);
        #1 rst_n = 1'b1;
        repeat (30) @(negedge in_clk);
        #1;
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b want 0", busy); end
        if (mark !== 1'b0) begin errors++; $display("FAIL post_rst_mark got %b want 0", mark); end
        if (done_count !== dc) begin errors++; $display("FAIL post_rst_done count %0d want %0d", done_count, dc); end
    endtask

    task automatic test_frame_patterns();
        logic [31:0] pats [5];
        int target;
        pats[0] = 32'h0000_0000;
        pats[1] = 32'hFFFF_FFFF;
        pats[2] = 32'h0000_FFFF;
        pats[3] = $urandom;
        pats[4] = $urandom;
        foreach (pats[p]) begin
            target = done_count + 1;
            pulse_start(pats[p]);
            data = $urandom;
            for (int i = 0; i < FRAME_CYC_LIMIT && done_count < target; i++) begin
                @(negedge in_clk); #1;
            end
            checks++;
            if (done_count < target) begin
                errors++; $display("FAIL frame_timeout data %h done_count %0d want %0d", pats[p], done_count, target);
            end else begin
                build_expected(pats[p]);
                checks += 3;
                if (run_diffs() !== 0) begin errors++; $display("FAIL frame_runs data %h bad runs %0d of %0d", pats[p], run_diffs(), exp_ln.size()); end
                if (snap_ticks !== expected_total(pats[p])) begin errors++; $display("FAIL frame_total data %h got %0d want %0d", pats[p], snap_ticks, expected_total(pats[p])); end
                if (snap_done_busy !== 1'b0) begin errors++; $display("FAIL done_busy data %h busy %b want 0", pats[p], snap_done_busy); end
            end
            repeat (3) @(negedge in_clk);
            #1;
            checks += 2;
            if (done_count !== target) begin errors++; $display("FAIL single_done data %h count %0d want %0d", pats[p], done_count, target); end
            if (busy !== 1'b0) begin errors++; $display("FAIL idle_after data %h busy %b want 0", pats[p], busy); end
        end
    endtask

    task automatic test_restart_ignored();
        logic [31:0] d0 = $urandom;
        int target = done_count + 1;
        pulse_start(d0);
        for (int i = 0; i < FRAME_CYC_LIMIT && frame_ticks < 10; i++) begin
            @(negedge in_clk); #1;
        end
        pulse_start(~d0);
        for (int i = 0; i < FRAME_CYC_LIMIT && frame_ticks < 400; i++) begin
            @(negedge in_clk); #1;
        end
        pulse_start(d0 ^ $urandom);
        for (int i = 0; i < FRAME_CYC_LIMIT && done_count < target; i++) begin
            @(negedge in_clk); #1;
        end
        repeat (5) @(negedge in_clk);
        #1;
        build_expected(d0);
        checks += 4;
        if (done_count !== target) begin errors++; $display("FAIL restart_done count %0d want %0d", done_count, target); end
        if (run_diffs() !== 0) begin errors++; $display("FAIL restart_runs bad runs %0d", run_diffs()); end
        if (snap_ticks !== expected_total(d0)) begin errors++; $display("FAIL restart_total got %0d want %0d", snap_ticks, expected_total(d0)); end
        if (busy !== 1'b0) begin errors++; $display("FAIL restart_queued busy %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1 = $urandom;
        int target = done_count + 1;
        @(negedge in_clk); #1;
        data  = d1;
        start = 1'b1;
        for (int i = 0; i < FRAME_CYC_LIMIT && done_count < target; i++) begin
            @(negedge in_clk); #1;
        end
        build_expected(d1);
        checks += 3;
        if (done_count !== target) begin errors++; $display("FAIL b2b_first_done count %0d want %0d", done_count, target); end
        if (snap_done_busy !== 1'b0) begin errors++; $display("FAIL b2b_gap busy %b want 0 in done cycle", snap_done_busy); end
        if (run_diffs() !== 0) begin errors++; $display("FAIL b2b_first_runs bad runs %0d", run_diffs()); end
        @(negedge in_clk); #1;
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got %b want 1", busy); end
        if (mark !== 1'b1) begin errors++; $display("FAIL b2b_restart_mark got %b want 1", mark); end
        start = 1'b0;
        data  = $urandom;
        target++;
        for (int i = 0; i < FRAME_CYC_LIMIT && done_count < target; i++) begin
            @(negedge in_clk); #1;
        end
        checks += 2;
        if (done_count !== target) begin errors++; $display("FAIL b2b_second_done count %0d want %0d", done_count, target); end
        if (run_diffs() !== 0) begin errors++; $display("FAIL b2b_second_runs bad runs %0d", run_diffs()); end
    endtask

    task automatic test_start_tick_coincident();
        logic [31:0] d2 = $urandom;
        bit found = 1'b0;
        int target = done_count + 1;
        repeat (3) @(negedge in_clk);
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge in_clk); #1;
            if (tick) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL coincident_setup no tick seen got 0 want 1");
        end else begin
            data  = d2;
            start = 1'b1;
            @(negedge in_clk); #1;
            start = 1'b0;
            for (int i = 0; i < FRAME_CYC_LIMIT && done_count < target; i++) begin
                @(negedge in_clk); #1;
            end
            build_expected(d2);
            checks += 3;
            if (done_count !== target) begin errors++; $display("FAIL coincident_done count %0d want %0d", done_count, target); end
            if (snap_ln.size() == 0 || snap_ln[0] !== HM) begin
                errors++; $display("FAIL coincident_hdr got %0d want %0d", (snap_ln.size() == 0) ? -1 : snap_ln[0], HM);
            end
            if (run_diffs() !== 0) begin errors++; $display("FAIL coincident_runs bad runs %0d", run_diffs()); end
        end
    endtask

    initial begin
        repeat (3) @(negedge in_clk);
        test_reset();
        test_frame_patterns();
        test_restart_ignored();
        test_back_to_back();
        test_start_tick_coincident();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1800000;
        $display("FAIL watchdog simulation time limit reached checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
